sensor_stream_scheduler: RTL and testbench

SENSOR_STREAM_SCHEDULER -- requirements
Module: sensor_stream_scheduler

---
 rtl/sensor_stream_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_sensor_stream_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_stream_scheduler.sv
// sensor_stream_scheduler
//
// Merges frames from an ADS1292 (72-bit read-data-continuous frame) and an
// MPR121 (12 touch bits) into framed byte packets for a UART transmitter:
//   0xA5, TYPE (0x01 ADS / 0x02 touch), DATA bytes MSB first, [CSUM]
// Each source has a one-deep pending register; frames arriving while it is
// occupied (and not being granted that cycle) are dropped and counted.
// Round-robin arbitration between the sources; ADS wins first after reset.
//
// Configuration macro:
//   SENSOR_SCHED_CHECKSUM_EN - when defined, a trailing checksum byte (XOR of
//   TYPE and all DATA bytes) is appended to every packet.
//
// Ports:
//   clk                 system clock, rising edge
//   rstn                asynchronous active-low reset
//   ads_frame_in        ADS1292 frame (status + 2 channels)
//   ads_frame_valid_in  single-cycle strobe qualifying ads_frame_in
//   touch_status_in     MPR121 electrode touch bits
//   touch_valid_in      single-cycle strobe qualifying touch_status_in
//   tx_data_out         byte to UART
//   tx_valid_out        tx_data_out holds a byte
//   tx_ready_in         UART accepts; transfer when valid and ready
//   drop_count_out      saturating count of discarded frames
//   busy_out            high whenever the FSM is not idle
module sensor_stream_scheduler (
  input  logic        clk,
  input  logic        rstn,
  input  logic [71:0] ads_frame_in,
  input  logic        ads_frame_valid_in,
  input  logic [11:0] touch_status_in,
  input  logic        touch_valid_in,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  output logic [7:0]  drop_count_out,
  output logic        busy_out
);

`ifdef SENSOR_SCHED_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHdr, StType, StData, StCsum} state_e;
`else
  typedef enum logic [2:0] {StIdle, StHdr, StType, StData} state_e;
`endif

  state_e      state_q, state_d;
  logic [71:0] ads_pend_q, ads_pend_d;
  logic        ads_flag_q, ads_flag_d;
  logic [11:0] touch_pend_q, touch_pend_d;
  logic        touch_flag_q, touch_flag_d;
  logic [71:0] shift_q, shift_d;
  logic        src_touch_q, src_touch_d;
  // Set means touch was granted last, so ADS wins the next tie.
  logic        last_touch_q, last_touch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  drop_q, drop_d;
`ifdef SENSOR_SCHED_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic       grant_ads, grant_touch, xfer;
  logic       ads_take, ads_drop, touch_take, touch_drop;
  logic [8:0] drop_sum;

  assign tx_valid_out   = (state_q != StIdle);
  assign busy_out       = (state_q != StIdle);
  assign tx_data_out    = tx_data_q;
  assign drop_count_out = drop_q;
  assign xfer           = tx_valid_out & tx_ready_in;

  // Arbitration happens only in idle.
  always_comb begin
    grant_ads   = 1'b0;
    grant_touch = 1'b0;
    if (state_q == StIdle) begin
      if (ads_flag_q && (!touch_flag_q || last_touch_q)) begin
        grant_ads = 1'b1;
      end else if (touch_flag_q) begin
        grant_touch = 1'b1;
      end
    end
  end

  // A grant frees the pending slot in the same cycle, so a coincident
  // strobe is captured rather than dropped.
  always_comb begin
    ads_take   = ads_frame_valid_in & (~ads_flag_q | grant_ads);
    ads_drop   = ads_frame_valid_in & ads_flag_q & ~grant_ads;
    touch_take = touch_valid_in & (~touch_flag_q | grant_touch);
    touch_drop = touch_valid_in & touch_flag_q & ~grant_touch;

    ads_pend_d   = ads_take ? ads_frame_in : ads_pend_q;
    ads_flag_d   = ads_take ? 1'b1 : (grant_ads ? 1'b0 : ads_flag_q);
    touch_pend_d = touch_take ? touch_status_in : touch_pend_q;
    touch_flag_d = touch_take ? 1'b1 : (grant_touch ? 1'b0 : touch_flag_q);

    drop_sum = {1'b0, drop_q} + {8'h00, ads_drop} + {8'h00, touch_drop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    src_touch_d  = src_touch_q;
    last_touch_d = last_touch_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
`ifdef SENSOR_SCHED_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (grant_ads) begin
          shift_d      = ads_pend_q;
          src_touch_d  = 1'b0;
          last_touch_d = 1'b0;
          tx_data_d    = 8'hA5;
          state_d      = StHdr;
        end else if (grant_touch) begin
          // Touch payload is left-aligned so both sources shift out from [71:64].
          shift_d      = {4'h0, touch_pend_q, 56'h0};
          src_touch_d  = 1'b1;
          last_touch_d = 1'b1;
          tx_data_d    = 8'hA5;
          state_d      = StHdr;
        end
      end
      StHdr: begin
        if (xfer) begin
          tx_data_d = src_touch_q ? 8'h02 : 8'h01;
`ifdef SENSOR_SCHED_CHECKSUM_EN
          csum_d    = src_touch_q ? 8'h02 : 8'h01;
`endif
          state_d   = StType;
        end
      end
      StType: begin
        if (xfer) begin
          tx_data_d = shift_q[71:64];
          shift_d   = {shift_q[63:0], 8'h00};
`ifdef SENSOR_SCHED_CHECKSUM_EN
          csum_d    = csum_q ^ shift_q[71:64];
`endif
          // Bytes remaining after the one just loaded.
          cnt_d     = src_touch_q ? 4'd1 : 4'd8;
          state_d   = StData;
        end
      end
      StData: begin
        if (xfer) begin
          if (cnt_q == 4'd0) begin
`ifdef SENSOR_SCHED_CHECKSUM_EN
            tx_data_d = csum_q;
            state_d   = StCsum;
`else
            tx_data_d = 8'h00;
            state_d   = StIdle;
`endif
          end else begin
            tx_data_d = shift_q[71:64];
            shift_d   = {shift_q[63:0], 8'h00};
`ifdef SENSOR_SCHED_CHECKSUM_EN
            csum_d    = csum_q ^ shift_q[71:64];
`endif
            cnt_d     = cnt_q - 4'd1;
          end
        end
      end
`ifdef SENSOR_SCHED_CHECKSUM_EN
      StCsum: begin
        if (xfer) begin
          tx_data_d = 8'h00;
          state_d   = StIdle;
        end
      end
`endif
      default: begin
        tx_data_d = 8'h00;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      ads_pend_q   <= '0;
      ads_flag_q   <= 1'b0;
      touch_pend_q <= '0;
      touch_flag_q <= 1'b0;
      shift_q      <= '0;
      src_touch_q  <= 1'b0;
      last_touch_q <= 1'b1;  // ADS has priority after reset
      cnt_q        <= '0;
      tx_data_q    <= 8'h00;
      drop_q       <= 8'h00;
`ifdef SENSOR_SCHED_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      ads_pend_q   <= ads_pend_d;
      ads_flag_q   <= ads_flag_d;
      touch_pend_q <= touch_pend_d;
      touch_flag_q <= touch_flag_d;
      shift_q      <= shift_d;
      src_touch_q  <= src_touch_d;
      last_touch_q <= last_touch_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      drop_q       <= drop_d;
`ifdef SENSOR_SCHED_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_sensor_stream_scheduler.sv
// Directed self-checking bench for sensor_stream_scheduler. Expected packets
// are hand-computed; the checksum byte is expected only when
// SENSOR_SCHED_CHECKSUM_EN is defined.
module tb_sensor_stream_scheduler;

  logic        clk;
  logic        rstn;
  logic [71:0] ads_frame_in;
  logic        ads_frame_valid_in;
  logic [11:0] touch_status_in;
  logic        touch_valid_in;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [7:0]  drop_count_out;
  logic        busy_out;

  int n_assert = 0;
  int n_fail   = 0;

  sensor_stream_scheduler dut (
    .clk                (clk),
    .rstn               (rstn),
    .ads_frame_in       (ads_frame_in),
    .ads_frame_valid_in (ads_frame_valid_in),
    .touch_status_in    (touch_status_in),
    .touch_valid_in     (touch_valid_in),
    .tx_data_out        (tx_data_out),
    .tx_valid_out       (tx_valid_out),
    .tx_ready_in        (tx_ready_in),
    .drop_count_out     (drop_count_out),
    .busy_out           (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample/drive point: 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Expects each byte in turn with tx_ready_in held high; bounded wait.
  task automatic recv(input logic [7:0] exp[$], input string tag);
    for (int i = 0; i < exp.size(); i++) begin
      int n = 0;
      while (!tx_valid_out && n < 64) begin
        step();
        n++;
      end
      chk($sformatf("%s_valid[%0d]", tag, i), {31'h0, tx_valid_out}, 32'h1);
      chk($sformatf("%s_byte[%0d]", tag, i), {24'h0, tx_data_out}, {24'h0, exp[i]});
      step();
    end
  endtask

  logic [7:0] ads_pkt[$];
  logic [7:0] touch_pkt[$];

  initial begin
    rstn               = 1'b0;
    ads_frame_in       = 72'h0;
    ads_frame_valid_in = 1'b0;
    touch_status_in    = 12'h0;
    touch_valid_in     = 1'b0;
    tx_ready_in        = 1'b1;

    ads_pkt = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                8'h12};
    touch_pkt = '{8'hA5, 8'h02, 8'h0A, 8'h5C};
`ifdef SENSOR_SCHED_CHECKSUM_EN
    ads_pkt.push_back(8'h13);
    touch_pkt.push_back(8'h54);
`endif

    // Reset values.
    step();
    chk("rst_valid", {31'h0, tx_valid_out}, 32'h0);
    chk("rst_data", {24'h0, tx_data_out}, 32'h0);
    chk("rst_busy", {31'h0, busy_out}, 32'h0);
    chk("rst_drop", {24'h0, drop_count_out}, 32'h0);
    rstn = 1'b1;
    step();
    step();

    // ADS packet with 2-cycle strobe-to-valid latency.
    ads_frame_in       = 72'h123456_789ABC_DEF012;
    ads_frame_valid_in = 1'b1;
    step();
    ads_frame_valid_in = 1'b0;
    chk("lat_n1_valid", {31'h0, tx_valid_out}, 32'h0);
    step();
    chk("lat_n2_valid", {31'h0, tx_valid_out}, 32'h1);
    chk("lat_n2_busy", {31'h0, busy_out}, 32'h1);
    recv(ads_pkt, "ads");
    chk("ads_end_valid", {31'h0, tx_valid_out}, 32'h0);
    chk("ads_end_busy", {31'h0, busy_out}, 32'h0);

    // Touch packet.
    touch_status_in = 12'hA5C;
    touch_valid_in  = 1'b1;
    step();
    touch_valid_in = 1'b0;
    recv(touch_pkt, "touch");
    chk("touch_end_valid", {31'h0, tx_valid_out}, 32'h0);

    // Simultaneous strobes after reset: ADS then touch, twice.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      ads_frame_valid_in = 1'b1;
      touch_valid_in     = 1'b1;
      step();
      ads_frame_valid_in = 1'b0;
      touch_valid_in     = 1'b0;
      recv(ads_pkt, $sformatf("pair%0d_ads", r));
      chk($sformatf("pair%0d_gap", r), {31'h0, tx_valid_out}, 32'h0);
      recv(touch_pkt, $sformatf("pair%0d_touch", r));
    end
    chk("pair_drop", {24'h0, drop_count_out}, 32'h0);

    // Stall: ready low, three more ADS strobes -> one captured, two dropped.
    do_reset();
    tx_ready_in        = 1'b0;
    ads_frame_valid_in = 1'b1;
    step();
    ads_frame_valid_in = 1'b0;
    step();
    chk("stall_valid", {31'h0, tx_valid_out}, 32'h1);
    chk("stall_hdr", {24'h0, tx_data_out}, 32'hA5);
    for (int k = 0; k < 3; k++) begin
      ads_frame_valid_in = 1'b1;
      step();
      chk($sformatf("stall_stable[%0d]", k), {24'h0, tx_data_out}, 32'hA5);
    end
    ads_frame_valid_in = 1'b0;
    step();
    chk("stall_drop", {24'h0, drop_count_out}, 32'h2);
    chk("stall_hold", {24'h0, tx_data_out}, 32'hA5);
    tx_ready_in = 1'b1;
    recv(ads_pkt, "stall_a");
    recv(ads_pkt, "stall_b");
    step();
    chk("stall_idle", {31'h0, busy_out}, 32'h0);

    // Reset in the middle of a packet, at the 5th byte.
    ads_frame_valid_in = 1'b1;
    step();
    ads_frame_valid_in = 1'b0;
    step();
    for (int k = 0; k < 4; k++) step();
    chk("mid_byte5", {24'h0, tx_data_out}, 32'h56);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, tx_valid_out}, 32'h0);
    chk("mid_rst_data", {24'h0, tx_data_out}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy_out}, 32'h0);
    chk("mid_rst_drop", {24'h0, drop_count_out}, 32'h0);
    step();
    rstn = 1'b1;
    step();
    chk("mid_post_idle", {31'h0, tx_valid_out}, 32'h0);
    ads_frame_valid_in = 1'b1;
    step();
    ads_frame_valid_in = 1'b0;
    recv(ads_pkt, "mid_next");

    // Drop counting: double increment, then saturation.
    do_reset();
    tx_ready_in        = 1'b0;
    ads_frame_valid_in = 1'b1;
    touch_valid_in     = 1'b1;
    step();
    chk("dbl_drop0", {24'h0, drop_count_out}, 32'h0);
    step();
    // ADS slot freed by its grant (captured), touch slot full (dropped).
    chk("dbl_drop1", {24'h0, drop_count_out}, 32'h1);
    step();
    chk("dbl_drop3", {24'h0, drop_count_out}, 32'h3);
    touch_valid_in = 1'b0;
    for (int k = 0; k < 300; k++) step();
    chk("sat_drop", {24'h0, drop_count_out}, 32'hFF);
    step();
    chk("sat_hold", {24'h0, drop_count_out}, 32'hFF);
    ads_frame_valid_in = 1'b0;
    tx_ready_in        = 1'b1;
    do_reset();
    chk("sat_rst", {24'h0, drop_count_out}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
